// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer controller: FSM state encoding and
// buffer depth derivation from the address width.
package buffer_pkg;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic int buf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/buffer_ptr.sv
// Modular pointer register with a variable per-cycle increment; wraps
// naturally at 2^ADDR_W.
module buffer_ptr #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (adv)
      ptr_d = ptr_q + inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/buffer_ctrl.sv
// Circular-buffer controller: wide write beats, sliding read window with
// variable release stride, and frame drain/done sequencing.
module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int PAR_WRITE   = 2,
  parameter int PAR_READ    = 4,
  parameter int BUFFER_ADDR = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_valid,
  input  logic                   wr_last,
  output logic                   wr_ready,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  input  logic [BUFFER_ADDR:0]   pop_count,
  output logic [BUFFER_ADDR:0]   rd_count,
  output logic                   frame_done,
  output logic                   buf_write_en,
  output logic [BUFFER_ADDR-1:0] buf_write_addr,
  output logic                   buf_read_en,
  output logic [BUFFER_ADDR-1:0] buf_read_addr,
  output logic [BUFFER_ADDR:0]   count
);

  localparam int DEPTH = buf_depth(BUFFER_ADDR);
  localparam int CW    = BUFFER_ADDR + 1;
  localparam logic [CW-1:0]          DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]          PW_C    = CW'(PAR_WRITE);
  localparam logic [CW-1:0]          PR_C    = CW'(PAR_READ);
  localparam logic [BUFFER_ADDR-1:0] PW_MOD  = BUFFER_ADDR'(PAR_WRITE % DEPTH);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] released;
  logic          wr_hs, rd_hs;

  always_comb begin
    // Readiness uses registered occupancy only, so no combinational path from the read side.
    wr_ready = (state_q == ST_FILL) && ((DEPTH_C - count_q) >= PW_C);
    rd_count = (count_q < PR_C) ? count_q : PR_C;
    case (state_q)
      ST_FILL:  rd_valid = (count_q >= PR_C);
      ST_DRAIN: rd_valid = (count_q != '0);
      default:  rd_valid = 1'b0;
    endcase

    wr_hs    = wr_valid && wr_ready && !flush;
    rd_hs    = rd_valid && rd_ready && !flush;
    released = '0;
    if (rd_hs)
      released = (pop_count < rd_count) ? pop_count : rd_count;

    count_d = count_q + (wr_hs ? PW_C : '0) - released;
    state_d = state_q;
    case (state_q)
      ST_FILL:  if (wr_hs && wr_last) state_d = ST_DRAIN;
      ST_DRAIN: if (count_d == '0)    state_d = ST_DONE;
      default:  state_d = ST_FILL;
    endcase

    if (flush) begin
      count_d = '0;
      state_d = ST_FILL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  buffer_ptr #(.ADDR_W(BUFFER_ADDR)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (wr_hs),
    .inc (PW_MOD),
    .ptr (buf_write_addr)
  );

  buffer_ptr #(.ADDR_W(BUFFER_ADDR)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .adv (rd_hs),
    .inc (released[BUFFER_ADDR-1:0]),
    .ptr (buf_read_addr)
  );

  assign buf_write_en = wr_hs;
  assign buf_read_en  = rd_valid;
  assign frame_done   = (state_q == ST_DONE);
  assign count        = count_q;

endmodule
